// File: rtl/imm_ctrl_sequencer_pkg.sv
// Shared encodings for the hardwired control sequencers: state codes,
// immediate-class opcodes and ALU function codes.
package imm_ctrl_sequencer_pkg;

  // T0..T5 keep the step numbers already used by the datapath bench.
  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_T0   = 5'd7,
    ST_T1   = 5'd8,
    ST_T2   = 5'd9,
    ST_T3   = 5'd10,
    ST_T4   = 5'd11,
    ST_T5   = 5'd12,
    ST_TRAP = 5'd31
  } state_e;

  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_AND = 1;
  localparam int unsigned ALU_OR  = 2;

endpackage

// File: rtl/imm_ctrl_sequencer_decoder.sv
// Opcode decoder for the immediate-ALU class: maps the IR opcode field to a
// legal flag and the ALU function. Purely combinational.
module imm_opcode_decoder
  import imm_ctrl_sequencer_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opc,
  output logic               legal,
  output logic [ALUOP_W-1:0] alu_op
);

  // Anything outside addi/andi/ori is reported illegal with alu_op = 0.
  always_comb begin
    legal  = 1'b0;
    alu_op = '0;
    case (opc)
      OPC_W'(OPC_ADDI): begin legal = 1'b1; alu_op = ALUOP_W'(ALU_ADD); end
      OPC_W'(OPC_ANDI): begin legal = 1'b1; alu_op = ALUOP_W'(ALU_AND); end
      OPC_W'(OPC_ORI):  begin legal = 1'b1; alu_op = ALUOP_W'(ALU_OR);  end
      default:          begin legal = 1'b0; alu_op = '0; end
    endcase
  end

endmodule

// File: rtl/imm_ctrl_sequencer.sv
// Control-step sequencer for fetch + immediate ALU (addi/andi/ori).
//
// state | meaning
// IDLE  | waiting for Start
// T0    | PC -> MAR
// T1    | memory read; waits for Mem_ready, PC increments on the ready cycle
// T2    | MDR -> IR
// T3    | Rb -> Y, opcode decode
// T4    | ALU (C operand) -> Z
// T5    | Z -> Ra, Done
// TRAP  | illegal opcode or memory timeout; left only by reset
//
// step reports the low four bits of the state code, so TRAP reads as 4'hF.
module imm_ctrl_sequencer
  import imm_ctrl_sequencer_pkg::*;
#(
  parameter int OPC_W      = 5,
  parameter int ALUOP_W    = 4,
  parameter int AUTO_FETCH = 0,
  parameter int WAIT_MAX   = 15
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Mem_ready,
  input  logic [31:0]        IR,
  output logic               PCout,
  output logic               MARin,
  output logic               Read,
  output logic               MDRin,
  output logic               PCin,
  output logic               IncPC,
  output logic               MDRout,
  output logic               IRin,
  output logic               Gra,
  output logic               Grb,
  output logic               Rout,
  output logic               Rin,
  output logic               Yin,
  output logic               Cout,
  output logic               Zin,
  output logic               ZLOout,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         step,
  output logic               Busy,
  output logic               Done,
  output logic               Trap
);

  // Counter only needs to reach WAIT_MAX-1; the next miss is the timeout.
  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [ALUOP_W-1:0] alu_q, alu_d;
  logic               trap_q, trap_d;
  logic               dec_legal;
  logic [ALUOP_W-1:0] dec_alu;
  logic [4:0]         state_bits;
  logic               ir_unused;

  imm_opcode_decoder #(
    .OPC_W   (OPC_W),
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .opc    (IR[31 -: OPC_W]),
    .legal  (dec_legal),
    .alu_op (dec_alu)
  );

  assign ir_unused  = ^IR[31-OPC_W:0];
  assign state_bits = state_q;
  assign step       = state_bits[3:0];
  assign alu_op     = alu_q;
  assign Trap       = trap_q;

  // State, wait counter, latched ALU function and sticky trap flag.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      alu_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      alu_q   <= alu_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state logic and strobe decode from the current state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    alu_d   = alu_q;
    trap_d  = trap_q;
    PCout = 1'b0; MARin = 1'b0; Read   = 1'b0; MDRin = 1'b0;
    PCin  = 1'b0; IncPC = 1'b0; MDRout = 1'b0; IRin  = 1'b0;
    Gra   = 1'b0; Grb   = 1'b0; Rout   = 1'b0; Rin   = 1'b0;
    Yin   = 1'b0; Cout  = 1'b0; Zin    = 1'b0; ZLOout = 1'b0;
    Busy  = 1'b0;
    Done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_T0;
      end
      ST_T0: begin
        Busy = 1'b1; PCout = 1'b1; MARin = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        Busy = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (Mem_ready) begin
          // PC bumps only on the data-valid cycle so a long wait still
          // increments exactly once.
          PCin    = 1'b1;
          IncPC   = 1'b1;
          wait_d  = '0;
          state_d = ST_T2;
        end else if (WAIT_MAX != 0) begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            trap_d  = 1'b1;
            state_d = ST_TRAP;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end
      ST_T2: begin
        Busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        Busy = 1'b1; Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        if (dec_legal) begin
          alu_d   = dec_alu;
          state_d = ST_T4;
        end else begin
          trap_d  = 1'b1;
          state_d = ST_TRAP;
        end
      end
      ST_T4: begin
        Busy = 1'b1; Cout = 1'b1; Zin = 1'b1;
        state_d = ST_T5;
      end
      ST_T5: begin
        Busy = 1'b1; ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        state_d = (AUTO_FETCH != 0) ? ST_T0 : ST_IDLE;
      end
      ST_TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
